// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// lsu_pkg : shared memory-op / data-type encodings and LSU state type
// Revision: 1.0
// ============================================================================
package lsu_pkg;

   localparam logic [1:0] MEM_LD = 2'b10;
   localparam logic [1:0] MEM_ST = 2'b01;

   localparam logic [1:0] DT_W   = 2'b00;
   localparam logic [1:0] DT_H   = 2'b01;
   localparam logic [1:0] DT_B   = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_REQ0  = 3'd1,
      ST_WAIT0 = 3'd2,
      ST_REQ1  = 3'd3,
      ST_WAIT1 = 3'd4,
      ST_DONE  = 3'd5
   } lsu_state_e;

   // Encoding 2'b11 behaves as a full word.
   function automatic logic [3:0] size_mask(input logic [1:0] dt);
      case (dt)
         DT_H:    size_mask = 4'b0011;
         DT_B:    size_mask = 4'b0001;
         default: size_mask = 4'b1111;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_ctrl_if.sv
`default_nettype none
// ============================================================================
// lsu_ctrl_if : word-wide req/gnt/rvalid memory bus between LSU and memory
// Revision: 1.0
// ============================================================================
interface lsu_ctrl_if;

   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  bmask;
   logic        gnt;
   logic        rvalid;
   logic [31:0] rdata;

   modport master (
      output req, we, addr, wdata, bmask,
      input  gnt, rvalid, rdata
   );

   modport slave (
      input  req, we, addr, wdata, bmask,
      output gnt, rvalid, rdata
   );

endinterface
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// lsu_align : lane positioning for stores, misalign detect, load merge/extend
// Revision: 1.0
// ============================================================================
module lsu_align
   import lsu_pkg::*;
(
   input  logic [1:0]  i_data_type,
   input  logic        i_unsigned,
   input  logic [1:0]  i_off,
   input  logic [31:0] i_wdata,
   input  logic [31:0] i_r0,
   input  logic [31:0] i_r1,
   output logic        o_misalign,
   output logic [7:0]  o_bmask,
   output logic [63:0] o_wdata,
   output logic [31:0] o_ld_data
);

   logic [3:0]  w_size;
   logic [4:0]  w_shamt;
   logic [31:0] w_ld_raw;

   always_comb begin
      w_size     = size_mask(i_data_type);
      w_shamt    = {i_off, 3'b000};
      o_misalign = ((w_size == 4'b1111) && (i_off != 2'b00)) ||
                   ((w_size == 4'b0011) && (i_off == 2'b11));
      // Upper half of each shifted vector is the second beat's lanes.
      o_bmask    = {4'b0000, w_size} << i_off;
      o_wdata    = {32'h0, i_wdata} << w_shamt;
      w_ld_raw   = 32'({i_r1, i_r0} >> w_shamt);
      case (i_data_type)
         DT_B:    o_ld_data = {{24{~i_unsigned & w_ld_raw[7]}},  w_ld_raw[7:0]};
         DT_H:    o_ld_data = {{16{~i_unsigned & w_ld_raw[15]}}, w_ld_raw[15:0]};
         default: o_ld_data = w_ld_raw;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
// lsu_ctrl : load/store unit; drives memory bus, splits misaligned accesses
// Revision: 1.0
// ============================================================================
module lsu_ctrl
   import lsu_pkg::*;
#(
   parameter bit SPLIT_EN = 1'b1
)(
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_req_vld,
   input  logic [1:0]  i_mem_wren,
   input  logic [1:0]  i_data_type,
   input  logic        i_unsigned,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_wdata,
   output logic        o_stall,
   output logic        o_ld_vld,
   output logic [31:0] o_ld_data,
   output logic        o_misalign,
   lsu_ctrl_if.master  bus
);

   lsu_state_e  state_q, state_d;
   logic        is_load_q, is_load_d;
   logic [1:0]  dtype_q, dtype_d;
   logic        unsigned_q, unsigned_d;
   logic [1:0]  off_q, off_d;
   logic [29:0] base_q, base_d;
   logic        split_q, split_d;
   logic        misalign_q, misalign_d;
   logic [31:0] r0_q, r0_d;
   logic [3:0]  bmask_hi_q, bmask_hi_d;
   logic [31:0] wdata_hi_q, wdata_hi_d;
   logic        bus_req_q, bus_req_d;
   logic        bus_we_q, bus_we_d;
   logic [31:0] bus_addr_q, bus_addr_d;
   logic [31:0] bus_wdata_q, bus_wdata_d;
   logic [3:0]  bus_bmask_q, bus_bmask_d;
   logic [31:0] ld_data_q, ld_data_d;

   logic        w_idle;
   logic        w_wait1;
   logic        w_mem_op;
   logic        w_is_ld;
   logic [1:0]  w_al_dtype;
   logic [1:0]  w_al_off;
   logic [31:0] w_al_r0;
   logic [31:0] w_al_r1;
   logic        w_misalign;
   logic [7:0]  w_bmask;
   logic [63:0] w_wdata;
   logic [31:0] w_ld_data;
   logic [31:0] w_beat1_addr;

   assign w_idle       = (state_q == ST_IDLE);
   assign w_wait1      = (state_q == ST_WAIT1);
   assign w_is_ld      = (i_mem_wren == MEM_LD);
   assign w_mem_op     = i_req_vld & (w_is_ld | (i_mem_wren == MEM_ST));
   assign w_beat1_addr = {base_q + 30'd1, 2'b00};

   // Store lanes come from the live inputs at accept; load merge uses latched fields.
   assign w_al_dtype = w_idle  ? i_data_type  : dtype_q;
   assign w_al_off   = w_idle  ? i_addr[1:0]  : off_q;
   assign w_al_r0    = w_wait1 ? r0_q         : bus.rdata;
   assign w_al_r1    = w_wait1 ? bus.rdata    : 32'h0;

   lsu_align u_align (
      .i_data_type (w_al_dtype),
      .i_unsigned  (unsigned_q),
      .i_off       (w_al_off),
      .i_wdata     (i_wdata),
      .i_r0        (w_al_r0),
      .i_r1        (w_al_r1),
      .o_misalign  (w_misalign),
      .o_bmask     (w_bmask),
      .o_wdata     (w_wdata),
      .o_ld_data   (w_ld_data)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= ST_IDLE;
         is_load_q   <= 1'b0;
         dtype_q     <= 2'b00;
         unsigned_q  <= 1'b0;
         off_q       <= 2'b00;
         base_q      <= '0;
         split_q     <= 1'b0;
         misalign_q  <= 1'b0;
         r0_q        <= '0;
         bmask_hi_q  <= '0;
         wdata_hi_q  <= '0;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= '0;
         bus_wdata_q <= '0;
         bus_bmask_q <= '0;
         ld_data_q   <= '0;
      end else begin
         state_q     <= state_d;
         is_load_q   <= is_load_d;
         dtype_q     <= dtype_d;
         unsigned_q  <= unsigned_d;
         off_q       <= off_d;
         base_q      <= base_d;
         split_q     <= split_d;
         misalign_q  <= misalign_d;
         r0_q        <= r0_d;
         bmask_hi_q  <= bmask_hi_d;
         wdata_hi_q  <= wdata_hi_d;
         bus_req_q   <= bus_req_d;
         bus_we_q    <= bus_we_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
         bus_bmask_q <= bus_bmask_d;
         ld_data_q   <= ld_data_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      is_load_d   = is_load_q;
      dtype_d     = dtype_q;
      unsigned_d  = unsigned_q;
      off_d       = off_q;
      base_d      = base_q;
      split_d     = split_q;
      misalign_d  = misalign_q;
      r0_d        = r0_q;
      bmask_hi_d  = bmask_hi_q;
      wdata_hi_d  = wdata_hi_q;
      bus_req_d   = bus_req_q;
      bus_we_d    = bus_we_q;
      bus_addr_d  = bus_addr_q;
      bus_wdata_d = bus_wdata_q;
      bus_bmask_d = bus_bmask_q;
      ld_data_d   = ld_data_q;

      case (state_q)
         ST_IDLE: begin
            if (w_mem_op) begin
               is_load_d  = w_is_ld;
               dtype_d    = i_data_type;
               unsigned_d = i_unsigned;
               off_d      = i_addr[1:0];
               base_d     = i_addr[31:2];
               split_d    = w_misalign & SPLIT_EN;
               misalign_d = w_misalign & ~SPLIT_EN;
               bmask_hi_d = w_bmask[7:4];
               wdata_hi_d = w_wdata[63:32];
               if (w_misalign && !SPLIT_EN) begin
                  state_d = ST_DONE;
                  if (w_is_ld) begin
                     ld_data_d = '0;
                  end
               end else begin
                  state_d     = ST_REQ0;
                  bus_req_d   = 1'b1;
                  bus_we_d    = ~w_is_ld;
                  bus_addr_d  = {i_addr[31:2], 2'b00};
                  bus_wdata_d = w_is_ld ? 32'h0 : w_wdata[31:0];
                  bus_bmask_d = w_is_ld ? 4'b1111 : w_bmask[3:0];
               end
            end
         end
         ST_REQ0: begin
            if (bus.gnt) begin
               if (is_load_q) begin
                  state_d   = ST_WAIT0;
                  bus_req_d = 1'b0;
               end else if (split_q) begin
                  // Request stays up; second store beat goes out back-to-back.
                  state_d     = ST_REQ1;
                  bus_addr_d  = w_beat1_addr;
                  bus_wdata_d = wdata_hi_q;
                  bus_bmask_d = bmask_hi_q;
               end else begin
                  state_d   = ST_DONE;
                  bus_req_d = 1'b0;
               end
            end
         end
         ST_WAIT0: begin
            if (bus.rvalid) begin
               r0_d = bus.rdata;
               if (split_q) begin
                  state_d    = ST_REQ1;
                  bus_req_d  = 1'b1;
                  bus_addr_d = w_beat1_addr;
               end else begin
                  state_d   = ST_DONE;
                  ld_data_d = w_ld_data;
               end
            end
         end
         ST_REQ1: begin
            if (bus.gnt) begin
               bus_req_d = 1'b0;
               state_d   = is_load_q ? ST_WAIT1 : ST_DONE;
            end
         end
         ST_WAIT1: begin
            if (bus.rvalid) begin
               state_d   = ST_DONE;
               ld_data_d = w_ld_data;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Gated by reset so the pipeline is released the moment reset asserts.
   assign o_stall    = w_idle ? (w_mem_op & i_rst_n) : (state_q != ST_DONE);
   assign o_ld_vld   = (state_q == ST_DONE) & is_load_q;
   assign o_misalign = (state_q == ST_DONE) & misalign_q;
   assign o_ld_data  = ld_data_q;

   assign bus.req    = bus_req_q;
   assign bus.we     = bus_we_q;
   assign bus.addr   = bus_addr_q;
   assign bus.wdata  = bus_wdata_q;
   assign bus.bmask  = bus_bmask_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// ============================================================================
// tb_lsu_ctrl : randomized bench for lsu_ctrl against a byte-level memory model
// Revision: 1.0
// ============================================================================
module tb_lsu_ctrl;
   import lsu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_vld, req_vld_ns;
   logic [1:0]  mem_wren, data_type;
   logic        uns;
   logic [31:0] addr, wdata;
   logic        stall, ld_vld, misalign;
   logic [31:0] ld_data;
   logic        stall_ns, ld_vld_ns, misalign_ns;
   logic [31:0] ld_data_ns;

   int errors = 0;
   int checks = 0;

   logic [31:0] mem [logic [31:0]];

   always #5 clk = ~clk;

   lsu_ctrl_if bus ();
   lsu_ctrl_if bus_ns ();

   lsu_ctrl #(.SPLIT_EN(1'b1)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_req_vld(req_vld), .i_mem_wren(mem_wren),
      .i_data_type(data_type), .i_unsigned(uns), .i_addr(addr), .i_wdata(wdata),
      .o_stall(stall), .o_ld_vld(ld_vld), .o_ld_data(ld_data), .o_misalign(misalign),
      .bus(bus)
   );

   lsu_ctrl #(.SPLIT_EN(1'b0)) dut_ns (
      .i_clk(clk), .i_rst_n(rst_n), .i_req_vld(req_vld_ns), .i_mem_wren(mem_wren),
      .i_data_type(data_type), .i_unsigned(uns), .i_addr(addr), .i_wdata(wdata),
      .o_stall(stall_ns), .o_ld_vld(ld_vld_ns), .o_ld_data(ld_data_ns), .o_misalign(misalign_ns),
      .bus(bus_ns)
   );

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] wa);
      if (mem.exists(wa)) return mem[wa];
      return (wa * 32'h9E3779B1) ^ 32'h5A5AA5A5;
   endfunction

   function automatic int nbytes(input logic [1:0] dt);
      if (dt == DT_H) return 2;
      if (dt == DT_B) return 1;
      return 4;
   endfunction

   // Reference load: gather bytes one at a time from the memory image, then extend.
   function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] dt, input logic u);
      logic [31:0] v = 32'h0;
      logic [31:0] low;
      logic [31:0] ba;
      logic [31:0] w;
      int n = nbytes(dt);
      for (int i = 0; i < n; i++) begin
         ba = a + 32'(i);
         w  = mem_word({ba[31:2], 2'b00});
         v[8*i +: 8] = w[8*ba[1:0] +: 8];
      end
      low = (n == 1) ? 32'h0000_00FF : (n == 2) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
      if (!u && v[8*n-1]) v = v | ~low;
      return v;
   endfunction

   function automatic logic [3:0] exp_bmask(input logic [31:0] a, input int n, input logic [31:0] wa);
      logic [3:0]  m = 4'b0000;
      logic [31:0] ba;
      for (int i = 0; i < n; i++) begin
         ba = a + 32'(i);
         if ({ba[31:2], 2'b00} == wa) m[ba[1:0]] = 1'b1;
      end
      return m;
   endfunction

   function automatic logic [31:0] exp_wdata(input logic [31:0] a, input int n, input logic [31:0] wd,
                                             input logic [31:0] wa);
      logic [31:0] d = 32'h0;
      logic [31:0] ba;
      for (int i = 0; i < n; i++) begin
         ba = a + 32'(i);
         if ({ba[31:2], 2'b00} == wa) d[8*ba[1:0] +: 8] = wd[8*i +: 8];
      end
      return d;
   endfunction

   function automatic logic [31:0] lane_mask(input logic [3:0] bm);
      logic [31:0] m = 32'h0;
      for (int k = 0; k < 4; k++) if (bm[k]) m[8*k +: 8] = 8'hFF;
      return m;
   endfunction

   // One instruction with a bus slave that grants after gd waiting cycles and returns data vd cycles later.
   task automatic do_op(input logic ld, input logic [1:0] dt, input logic u, input logic [31:0] a,
                        input logic [31:0] wd, input int gd, input int vd);
      int          n = nbytes(dt);
      int          nb;
      int          beat = 0, gcnt = 0, rvcnt = 0, stalls = 0;
      bit          pend = 0, done = 0;
      logic [31:0] base = {a[31:2], 2'b00};
      logic [31:0] wa;
      logic [31:0] exp_ld;
      logic [3:0]  ebm;
      nb     = (((a + 32'(n - 1)) >> 2) != (a >> 2)) ? 2 : 1;
      exp_ld = model_load(a, dt, u);
      @(negedge clk);
      req_vld = 1'b1; mem_wren = ld ? MEM_LD : MEM_ST; data_type = dt; uns = u; addr = a; wdata = wd;
      for (int cyc = 0; cyc < 100 && !done; cyc++) begin
         #1;
         if (stall) begin
            stalls++;
            chk("ld_vld_while_stalled", ld_vld, 1'b0);
         end else begin
            done = 1;
            chk("stall_cycles", stalls, 1 + nb * (gd + 1 + (ld ? vd : 0)));
            chk("beats", beat, nb);
            chk("ld_vld", ld_vld, ld);
            if (ld) chk("ld_data", ld_data, exp_ld);
            chk("misalign_split", misalign, 1'b0);
            chk("req_in_done", bus.req, 1'b0);
            req_vld = 1'b0;
         end
         bus.gnt = 1'b0; bus.rvalid = 1'b0; bus.rdata = $urandom;
         if (!done) begin
            if (pend) begin
               rvcnt--;
               if (rvcnt == 0) begin
                  pend = 0; bus.rvalid = 1'b1;
                  bus.rdata = mem_word(base + 32'(4 * (beat - 1)));
               end
            end else if ($urandom_range(3) == 0) begin
               bus.rvalid = 1'b1;
            end
            if (bus.req) begin
               if (beat >= nb) begin
                  chk("extra_beat", beat, nb - 1);
               end else begin
                  wa  = base + 32'(4 * beat);
                  ebm = ld ? 4'b1111 : exp_bmask(a, n, wa);
                  chk("bus_addr", bus.addr, wa);
                  chk("bus_we", bus.we, !ld);
                  chk("bus_bmask", bus.bmask, ebm);
                  if (!ld) chk("bus_wdata", bus.wdata & lane_mask(ebm), exp_wdata(a, n, wd, wa));
                  if (gcnt == gd) begin
                     bus.gnt = 1'b1; gcnt = 0; beat++;
                     if (ld) begin pend = 1; rvcnt = vd; end
                  end else begin
                     gcnt++;
                  end
               end
            end else if ($urandom_range(3) == 0) begin
               bus.gnt = 1'b1;
            end
         end
         @(negedge clk);
      end
      if (!done) chk("op_timeout", 1'b1, 1'b0);
      req_vld = 1'b0; bus.gnt = 1'b0; bus.rvalid = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [1:0]  rdt;
      logic        rld;
      logic [31:0] ra;
      rst_n = 1'b0; req_vld = 1'b0; req_vld_ns = 1'b0;
      mem_wren = 2'b00; data_type = 2'b00; uns = 1'b0; addr = '0; wdata = '0;
      bus.gnt = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0;
      bus_ns.gnt = 1'b0; bus_ns.rvalid = 1'b0; bus_ns.rdata = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_stall", stall, 1'b0);
      chk("rst_req", bus.req, 1'b0);
      chk("rst_we", bus.we, 1'b0);
      chk("rst_addr", bus.addr, 32'h0);
      chk("rst_wdata", bus.wdata, 32'h0);
      chk("rst_bmask", bus.bmask, 4'h0);
      chk("rst_ld_vld", ld_vld, 1'b0);
      chk("rst_ld_data", ld_data, 32'h0);
      chk("rst_misalign", misalign, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // Misaligned word load with splitting disabled.
      @(negedge clk);
      req_vld_ns = 1'b1; mem_wren = MEM_LD; data_type = DT_W; uns = 1'b0; addr = 32'h101;
      #1;
      chk("ns_stall_accept", stall_ns, 1'b1);
      chk("ns_req_accept", bus_ns.req, 1'b0);
      @(negedge clk); #1;
      chk("ns_stall_done", stall_ns, 1'b0);
      chk("ns_ld_vld", ld_vld_ns, 1'b1);
      chk("ns_ld_data", ld_data_ns, 32'h0);
      chk("ns_misalign", misalign_ns, 1'b1);
      chk("ns_req_done", bus_ns.req, 1'b0);
      req_vld_ns = 1'b0;
      @(negedge clk); #1;
      chk("ns_misalign_pulse", misalign_ns, 1'b0);
      chk("ns_ld_vld_pulse", ld_vld_ns, 1'b0);

      mem[32'h100] = 32'h8899AABB;
      do_op(1'b1, DT_W, 1'b0, 32'h100, 32'h0, 0, 1);
      mem[32'h100] = 32'h80000000;
      do_op(1'b1, DT_B, 1'b0, 32'h103, 32'h0, 0, 1);
      do_op(1'b1, DT_B, 1'b1, 32'h103, 32'h0, 0, 1);
      mem[32'h100] = 32'hABCD0000;
      do_op(1'b1, DT_H, 1'b1, 32'h102, 32'h0, 0, 1);
      do_op(1'b0, DT_H, 1'b0, 32'h102, 32'h1234ABCD, 0, 1);
      do_op(1'b0, DT_W, 1'b0, 32'h101, 32'h11223344, 0, 1);
      mem[32'h100] = 32'h44332211;
      mem[32'h104] = 32'h88776655;
      do_op(1'b1, DT_W, 1'b0, 32'h102, 32'h0, 0, 1);
      do_op(1'b1, DT_W, 1'b0, 32'hFFFFFFFE, 32'h0, 1, 2);
      do_op(1'b0, DT_H, 1'b0, 32'h0000_0203, 32'hCAFE_BEEF, 3, 1);
      do_op(1'b1, DT_W, 1'b0, 32'h0000_0300, 32'h0, 3, 1);

      for (int k = 0; k < 150; k++) begin
         rld = 1'($urandom_range(1));
         rdt = 2'($urandom_range(3));
         ra  = ($urandom_range(7) == 0) ? (32'hFFFF_FFFC | 32'($urandom_range(3))) : $urandom;
         do_op(rld, rdt, 1'($urandom_range(1)), ra, $urandom,
               $urandom_range(3), $urandom_range(3, 1));
      end

      // Reset while waiting for read data; the late rvalid must be ignored.
      @(negedge clk);
      req_vld = 1'b1; mem_wren = MEM_LD; data_type = DT_W; addr = 32'h200;
      @(negedge clk); #1;
      chk("rr_req_up", bus.req, 1'b1);
      bus.gnt = 1'b1;
      @(negedge clk);
      bus.gnt = 1'b0;
      #1;
      rst_n = 1'b0;
      #1;
      chk("rr_req_reset", bus.req, 1'b0);
      chk("rr_stall_reset", stall, 1'b0);
      chk("rr_addr_reset", bus.addr, 32'h0);
      @(negedge clk);
      req_vld = 1'b0; rst_n = 1'b1;
      @(negedge clk);
      bus.rvalid = 1'b1; bus.rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      bus.rvalid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("rr_no_ld_vld", ld_vld, 1'b0);
         chk("rr_no_stall", stall, 1'b0);
         @(negedge clk);
      end

      // Non-memory encodings never stall or touch the bus.
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         req_vld = 1'b1; mem_wren = (k == 0) ? 2'b00 : 2'b11; addr = 32'h101;
         #1;
         chk("nop_stall", stall, 1'b0);
         chk("nop_req", bus.req, 1'b0);
         @(negedge clk); #1;
         chk("nop_stall_next", stall, 1'b0);
         chk("nop_req_next", bus.req, 1'b0);
         req_vld = 1'b0;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
